// File: rtl/sc_matrix_chain_driver_if.sv
// Signal bundle between the game-state logic and the MAX7219 chain driver.
// The driver also owns the three serial pins toward the matrix modules.
interface sc_matrix_chain_driver_if #(
  parameter int NUM_DEVICES = 1
);
  logic [64*NUM_DEVICES-1:0] SC_MATRIXCHAIN_frame_InBUS;
  logic                      SC_MATRIXCHAIN_load_InLow;
  logic [3:0]                SC_MATRIXCHAIN_intensity_InBUS;
  logic                      SC_MATRIXCHAIN_blank_InLow;
  logic                      SC_MATRIXCHAIN_ready_Out;
  logic                      SC_MATRIXCHAIN_frameDone_OutLow;
  logic                      SC_MATRIXCHAIN_max7219DIN_Out;
  logic                      SC_MATRIXCHAIN_max7219NCS_Out;
  logic                      SC_MATRIXCHAIN_max7219CLK_Out;

  modport master (
    output SC_MATRIXCHAIN_frame_InBUS, SC_MATRIXCHAIN_load_InLow,
           SC_MATRIXCHAIN_intensity_InBUS, SC_MATRIXCHAIN_blank_InLow,
    input  SC_MATRIXCHAIN_ready_Out, SC_MATRIXCHAIN_frameDone_OutLow,
           SC_MATRIXCHAIN_max7219DIN_Out, SC_MATRIXCHAIN_max7219NCS_Out,
           SC_MATRIXCHAIN_max7219CLK_Out
  );

  modport slave (
    input  SC_MATRIXCHAIN_frame_InBUS, SC_MATRIXCHAIN_load_InLow,
           SC_MATRIXCHAIN_intensity_InBUS, SC_MATRIXCHAIN_blank_InLow,
    output SC_MATRIXCHAIN_ready_Out, SC_MATRIXCHAIN_frameDone_OutLow,
           SC_MATRIXCHAIN_max7219DIN_Out, SC_MATRIXCHAIN_max7219NCS_Out,
           SC_MATRIXCHAIN_max7219CLK_Out
  );
endinterface

// File: rtl/sc_matrix_chain_driver.sv
// MAX7219 daisy-chain driver: init sequence, double-buffered frame and
// continuous row refresh with blank/intensity commands inserted on change.
module sc_matrix_chain_driver #(
  parameter int         NUM_DEVICES    = 1,
  parameter int         CLKDIV         = 4,
  parameter bit         ROTATE         = 1'b0,
  parameter logic [3:0] INIT_INTENSITY = 4'hA
) (
  input logic SC_MATRIXCHAIN_CLOCK_50,
  input logic SC_MATRIXCHAIN_RESET_InLow,
  sc_matrix_chain_driver_if.slave bus
);
  localparam int FRAME_W = 64 * NUM_DEVICES;
  localparam int WORD_W  = 16 * NUM_DEVICES;
  localparam int DIV_W   = $clog2(2 * CLKDIV) + 1;
  localparam int BIT_W   = $clog2(WORD_W) + 1;

  typedef enum logic [2:0] {INIT, IDLE_SEL, SHIFT_LOW, SHIFT_HIGH, GAP} stateT;

  logic clk, rstInN, rstN;
  logic [1:0] rstSync;
  stateT state, stateNext;
  logic [DIV_W-1:0] divCnt, divNext;
  logic [BIT_W-1:0] bitCnt, bitNext;
  logic [WORD_W-1:0] shiftReg, shiftNext, rowWord;
  logic [FRAME_W-1:0] activeBuf, pendingBuf;
  logic [2:0] initStep, rowPtr;
  logic [3:0] lastIntensity;
  logic [15:0] cmdWord;
  logic rowSel7, pendingVld, lastNormal, shifting;
  logic selInit, selBlank, selIntensity, selRow, commitNow;
  logic ncsQ, clkQ, dinQ, frameDoneQ;

  assign clk    = SC_MATRIXCHAIN_CLOCK_50;
  assign rstInN = SC_MATRIXCHAIN_RESET_InLow;

  function automatic logic [15:0] initWord(input logic [2:0] step);
    case (step)
      3'd0:    initWord = 16'h0F00;
      3'd1:    initWord = 16'h0B07;
      3'd2:    initWord = 16'h0900;
      3'd3:    initWord = {12'h0A0, INIT_INTENSITY};
      default: initWord = 16'h0C01;
    endcase
  endfunction

  // ROTATE sends column (7-r) of the tile, row 0 landing on the MSB.
  function automatic logic [7:0] tileRow(input logic [63:0] tile, input logic [2:0] r);
    logic [7:0] res;
    res = '0;
    if (ROTATE) begin
      for (int k = 0; k < 8; k++) res[7-k] = tile[k*8 + 7 - int'(r)];
    end else begin
      res = tile[int'(r)*8 +: 8];
    end
    return res;
  endfunction

  // Reset asserts immediately, releases two clocks after the pin goes high.
  always_ff @(posedge clk or negedge rstInN) begin
    if (!rstInN) rstSync <= 2'b00;
    else         rstSync <= {rstSync[0], 1'b1};
  end
  assign rstN = rstSync[1];

  always_comb begin
    rowWord = '0;
    for (int d = 0; d < NUM_DEVICES; d++)
      rowWord[d*16 +: 16] = {4'h0, {1'b0, rowPtr} + 4'd1, tileRow(activeBuf[d*64 +: 64], rowPtr)};
  end

  always_comb begin
    stateNext    = state;
    divNext      = divCnt;
    bitNext      = bitCnt;
    shiftNext    = shiftReg;
    cmdWord      = 16'h0000;
    selInit      = 1'b0;
    selBlank     = 1'b0;
    selIntensity = 1'b0;
    selRow       = 1'b0;
    commitNow    = 1'b0;
    case (state)
      INIT: stateNext = IDLE_SEL;
      IDLE_SEL: begin
        if (initStep < 3'd5) begin
          selInit = 1'b1;
          cmdWord = initWord(initStep);
        end else if (bus.SC_MATRIXCHAIN_blank_InLow != lastNormal) begin
          selBlank = 1'b1;
          cmdWord  = {8'h0C, 7'd0, bus.SC_MATRIXCHAIN_blank_InLow};
        end else if (bus.SC_MATRIXCHAIN_intensity_InBUS != lastIntensity) begin
          selIntensity = 1'b1;
          cmdWord      = {12'h0A0, bus.SC_MATRIXCHAIN_intensity_InBUS};
        end else begin
          selRow = 1'b1;
        end
        shiftNext = selRow ? rowWord : {NUM_DEVICES{cmdWord}};
        bitNext   = BIT_W'(WORD_W - 1);
        divNext   = '0;
        stateNext = SHIFT_LOW;
      end
      SHIFT_LOW: begin
        if (divCnt == DIV_W'(CLKDIV - 1)) begin
          divNext   = '0;
          stateNext = SHIFT_HIGH;
        end else begin
          divNext = divCnt + 1'b1;
        end
      end
      SHIFT_HIGH: begin
        if (divCnt == DIV_W'(CLKDIV - 1)) begin
          divNext = '0;
          if (bitCnt == '0) begin
            stateNext = GAP;
          end else begin
            bitNext   = bitCnt - 1'b1;
            shiftNext = shiftReg << 1;
            stateNext = SHIFT_LOW;
          end
        end else begin
          divNext = divCnt + 1'b1;
        end
      end
      GAP: begin
        // IDLE_SEL supplies the last NCS-high cycle of the gap.
        if (divCnt == DIV_W'(2 * CLKDIV - 2)) begin
          divNext   = '0;
          stateNext = IDLE_SEL;
          commitNow = rowSel7 && pendingVld;
        end else begin
          divNext = divCnt + 1'b1;
        end
      end
      default: stateNext = INIT;
    endcase
  end

  assign shifting = (stateNext == SHIFT_LOW) || (stateNext == SHIFT_HIGH);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state         <= INIT;
      divCnt        <= '0;
      bitCnt        <= '0;
      shiftReg      <= '0;
      initStep      <= 3'd0;
      rowPtr        <= 3'd0;
      rowSel7       <= 1'b0;
      lastIntensity <= 4'h0;
      lastNormal    <= 1'b0;
      activeBuf     <= '0;
      pendingBuf    <= '0;
      pendingVld    <= 1'b0;
      ncsQ          <= 1'b1;
      clkQ          <= 1'b0;
      dinQ          <= 1'b0;
      frameDoneQ    <= 1'b1;
    end else begin
      state    <= stateNext;
      divCnt   <= divNext;
      bitCnt   <= bitNext;
      shiftReg <= shiftNext;
      ncsQ     <= !shifting;
      clkQ     <= (stateNext == SHIFT_HIGH);
      dinQ     <= shifting & shiftNext[WORD_W-1];
      if (state == IDLE_SEL) begin
        if (selInit) begin
          initStep <= initStep + 3'd1;
          if (initStep == 3'd3) lastIntensity <= INIT_INTENSITY;
          if (initStep == 3'd4) lastNormal <= 1'b1;
        end
        if (selBlank) lastNormal <= bus.SC_MATRIXCHAIN_blank_InLow;
        if (selIntensity) lastIntensity <= bus.SC_MATRIXCHAIN_intensity_InBUS;
        if (selRow) rowPtr <= rowPtr + 3'd1;
        rowSel7 <= selRow && (rowPtr == 3'd7);
      end
      frameDoneQ <= !commitNow;
      if (commitNow) activeBuf <= pendingBuf;
      // A load coinciding with a commit becomes the next pending frame.
      if (!bus.SC_MATRIXCHAIN_load_InLow) begin
        pendingBuf <= bus.SC_MATRIXCHAIN_frame_InBUS;
        pendingVld <= 1'b1;
      end else if (commitNow) begin
        pendingVld <= 1'b0;
      end
    end
  end

  assign bus.SC_MATRIXCHAIN_ready_Out        = !pendingVld;
  assign bus.SC_MATRIXCHAIN_frameDone_OutLow = frameDoneQ;
  assign bus.SC_MATRIXCHAIN_max7219DIN_Out   = dinQ;
  assign bus.SC_MATRIXCHAIN_max7219NCS_Out   = ncsQ;
  assign bus.SC_MATRIXCHAIN_max7219CLK_Out   = clkQ;
endmodule

// File: tb/tb_sc_matrix_chain_driver.sv
// Bench for the MAX7219 chain driver: a 2-device plain instance and a
// 1-device transposing instance, both decoded from their serial pins.
`timescale 1ns/1ps
module tb_sc_matrix_chain_driver;
  localparam int         CLKDIV   = 2;
  localparam logic [3:0] INIT_INT = 4'hA;
  localparam int         LIMIT    = 6000;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  sc_matrix_chain_driver_if #(.NUM_DEVICES(2)) busA ();
  sc_matrix_chain_driver_if #(.NUM_DEVICES(1)) busB ();

  sc_matrix_chain_driver #(.NUM_DEVICES(2), .CLKDIV(CLKDIV), .ROTATE(1'b0), .INIT_INTENSITY(INIT_INT)) dutA (
    .SC_MATRIXCHAIN_CLOCK_50(clk), .SC_MATRIXCHAIN_RESET_InLow(rstN), .bus(busA));
  sc_matrix_chain_driver #(.NUM_DEVICES(1), .CLKDIV(CLKDIV), .ROTATE(1'b1), .INIT_INTENSITY(INIT_INT)) dutB (
    .SC_MATRIXCHAIN_CLOCK_50(clk), .SC_MATRIXCHAIN_RESET_InLow(rstN), .bus(busB));

  logic [127:0] frameIn [2];
  logic [3:0]   intensIn [2];
  logic [1:0]   loadIn, blankIn;
  logic [1:0]   ncs, sclk, din, fdn, rdy;

  assign busA.SC_MATRIXCHAIN_frame_InBUS     = frameIn[0];
  assign busA.SC_MATRIXCHAIN_load_InLow      = loadIn[0];
  assign busA.SC_MATRIXCHAIN_intensity_InBUS = intensIn[0];
  assign busA.SC_MATRIXCHAIN_blank_InLow     = blankIn[0];
  assign busB.SC_MATRIXCHAIN_frame_InBUS     = frameIn[1][63:0];
  assign busB.SC_MATRIXCHAIN_load_InLow      = loadIn[1];
  assign busB.SC_MATRIXCHAIN_intensity_InBUS = intensIn[1];
  assign busB.SC_MATRIXCHAIN_blank_InLow     = blankIn[1];
  assign ncs[0]  = busA.SC_MATRIXCHAIN_max7219NCS_Out;
  assign sclk[0] = busA.SC_MATRIXCHAIN_max7219CLK_Out;
  assign din[0]  = busA.SC_MATRIXCHAIN_max7219DIN_Out;
  assign fdn[0]  = busA.SC_MATRIXCHAIN_frameDone_OutLow;
  assign rdy[0]  = busA.SC_MATRIXCHAIN_ready_Out;
  assign ncs[1]  = busB.SC_MATRIXCHAIN_max7219NCS_Out;
  assign sclk[1] = busB.SC_MATRIXCHAIN_max7219CLK_Out;
  assign din[1]  = busB.SC_MATRIXCHAIN_max7219DIN_Out;
  assign fdn[1]  = busB.SC_MATRIXCHAIN_frameDone_OutLow;
  assign rdy[1]  = busB.SC_MATRIXCHAIN_ready_Out;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, one slot per instance (0 = 2-device, 1 = rotated).
  logic [127:0] actF [2];
  logic [127:0] pendF [2];
  bit           pendV [2];
  int           initIdx [2];
  int           rowP [2];
  bit           lastNorm [2];
  logic [3:0]   lastInt [2];
  bit           rowTx [2];
  bit           expPulse [2];
  bit           highValid [2];
  int           curAddr [2];
  logic [31:0]  expW [2];
  logic [31:0]  cap [2];
  int           bits [2], lowCnt [2], highCnt [2], fdCnt [2], txnCount [2];
  logic [1:0]   prevNcs, prevSclk;
  logic [15:0]  initSeq [5];
  assign initSeq[0] = 16'h0F00;
  assign initSeq[1] = 16'h0B07;
  assign initSeq[2] = 16'h0900;
  assign initSeq[3] = {12'h0A0, INIT_INT};
  assign initSeq[4] = 16'h0C01;

  function automatic int ndev(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic string tg(input string name, input int i);
    return $sformatf("%s[%0d]", name, i);
  endfunction

  function automatic logic [31:0] rep(input logic [15:0] w, input int n);
    return (n == 2) ? {w, w} : {16'h0000, w};
  endfunction

  // Display byte for one tile: the row itself, or the transposed column.
  function automatic logic [7:0] rowByte(input logic [63:0] tile, input int r, input bit rot);
    logic [7:0] m [8];
    logic [7:0] b;
    for (int k = 0; k < 8; k++) m[k] = tile[k*8 +: 8];
    if (!rot) return m[r];
    b = '0;
    for (int k = 0; k < 8; k++) b[7-k] = m[k][7-r];
    return b;
  endfunction

  function automatic logic [31:0] rowWordModel(input logic [127:0] f, input int r, input int n, input bit rot);
    logic [31:0] w;
    w = '0;
    for (int d = n - 1; d >= 0; d--) w = {w[15:0], 8'(r + 1), rowByte(f[d*64 +: 64], r, rot)};
    return w;
  endfunction

  task automatic txnStart(input int i);
    if (highValid[i]) chk(tg("gapLen", i), highCnt[i], 2 * CLKDIV);
    chk(tg("frameDonePulses", i), fdCnt[i], {31'd0, expPulse[i]});
    chk(tg("ready", i), {31'd0, rdy[i]}, {31'd0, !pendV[i]});
    fdCnt[i] = 0;
    expPulse[i] = 1'b0;
    rowTx[i] = 1'b0;
    if (initIdx[i] < 5) begin
      if (initIdx[i] == 3) lastInt[i] = INIT_INT;
      if (initIdx[i] == 4) lastNorm[i] = 1'b1;
      expW[i] = rep(initSeq[initIdx[i]], ndev(i));
      initIdx[i]++;
    end else if (blankIn[i] != lastNorm[i]) begin
      lastNorm[i] = blankIn[i];
      expW[i] = rep({8'h0C, 7'd0, blankIn[i]}, ndev(i));
    end else if (intensIn[i] != lastInt[i]) begin
      lastInt[i] = intensIn[i];
      expW[i] = rep({12'h0A0, intensIn[i]}, ndev(i));
    end else begin
      expW[i] = rowWordModel(actF[i], rowP[i], ndev(i), i == 1);
      rowTx[i] = (rowP[i] == 7);
      rowP[i] = (rowP[i] + 1) % 8;
    end
    curAddr[i] = int'(expW[i][15:8]);
    cap[i] = '0;
    bits[i] = 0;
    lowCnt[i] = 0;
    txnCount[i]++;
  endtask

  task automatic txnEnd(input int i);
    chk(tg("ncsLowLen", i), lowCnt[i], 32 * ndev(i) * CLKDIV);
    chk(tg("bitCount", i), bits[i], 16 * ndev(i));
    chk(tg("word", i), cap[i], expW[i]);
    chk(tg("idlePins", i), {30'd0, sclk[i], din[i]}, 32'd0);
    if (rowTx[i] && pendV[i]) begin
      actF[i] = pendF[i];
      pendV[i] = 1'b0;
      expPulse[i] = 1'b1;
    end
    highCnt[i] = 0;
    highValid[i] = 1'b1;
    curAddr[i] = -1;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstN) begin
        actF[i] = '0; pendF[i] = '0; pendV[i] = 1'b0;
        initIdx[i] = 0; rowP[i] = 0; lastNorm[i] = 1'b0; lastInt[i] = 4'h0;
        rowTx[i] = 1'b0; expPulse[i] = 1'b0; highValid[i] = 1'b0; curAddr[i] = -1;
        bits[i] = 0; lowCnt[i] = 0; highCnt[i] = 0; fdCnt[i] = 0; cap[i] = '0;
        prevNcs[i] = 1'b1; prevSclk[i] = 1'b0;
      end else begin
        if (!fdn[i]) fdCnt[i]++;
        if (prevNcs[i] && !ncs[i]) txnStart(i);
        else if (!prevNcs[i] && ncs[i]) txnEnd(i);
        if (!ncs[i]) begin
          lowCnt[i]++;
          if (sclk[i] && !prevSclk[i]) begin
            cap[i] = {cap[i][30:0], din[i]};
            bits[i]++;
          end
        end else begin
          highCnt[i]++;
        end
        prevNcs[i] = ncs[i];
        prevSclk[i] = sclk[i];
      end
    end
  end

  // Returns a few cycles into the transaction carrying the given address.
  task automatic waitTxn(input int i, input int addr);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(ncs[i] == 1'b0 && curAddr[i] == addr && lowCnt[i] == 3) && n < LIMIT);
    chk(tg("waitInTime", i), {31'd0, n < LIMIT}, 32'd1);
  endtask

  task automatic doLoad(input int i, input logic [127:0] f);
    frameIn[i] = f;
    loadIn[i] = 1'b0;
    pendF[i] = f;
    pendV[i] = 1'b1;
    @(negedge clk); #1;
    loadIn[i] = 1'b1;
  endtask

  task automatic chkIdlePins(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk(tg({tag, "Ncs"}, i), {31'd0, ncs[i]}, 32'd1);
      chk(tg({tag, "Clk"}, i), {31'd0, sclk[i]}, 32'd0);
      chk(tg({tag, "Din"}, i), {31'd0, din[i]}, 32'd0);
    end
  endtask

  initial begin
    int ii, aa, act;
    rstN = 1'b0;
    loadIn = 2'b11;
    blankIn = 2'b11;
    intensIn[0] = INIT_INT;
    intensIn[1] = INIT_INT;
    frameIn[0] = '0;
    frameIn[1] = '0;
    repeat (3) @(negedge clk); #1;
    chkIdlePins("rst");
    for (int i = 0; i < 2; i++) begin
      chk(tg("rstReady", i), {31'd0, rdy[i]}, 32'd1);
      chk(tg("rstFrameDone", i), {31'd0, fdn[i]}, 32'd1);
    end
    rstN = 1'b1;

    // All rows 0x81 loaded while row 3 is on the wire.
    waitTxn(0, 4);
    doLoad(0, {16{8'h81}});
    // Transposed tile: only row0 bit 7 lit.
    waitTxn(1, 3);
    doLoad(1, 128'h80);
    // Far device all on, near device all off.
    waitTxn(0, 2);
    doLoad(0, {{8{8'hFF}}, {8{8'h00}}});
    // Intensity and blank change together during row 2.
    waitTxn(0, 3);
    intensIn[0] = 4'h3;
    blankIn[0] = 1'b0;
    waitTxn(0, 6);
    blankIn[0] = 1'b1;
    waitTxn(1, 5);
    intensIn[1] = 4'hF;

    for (int k = 0; k < 16; k++) begin
      ii = $urandom_range(0, 1);
      aa = $urandom_range(1, 8);
      act = $urandom_range(0, 3);
      waitTxn(ii, aa);
      case (act)
        0: doLoad(ii, {$urandom, $urandom, $urandom, $urandom});
        1: begin
          doLoad(ii, {$urandom, $urandom, $urandom, $urandom});
          doLoad(ii, {$urandom, $urandom, $urandom, $urandom});
        end
        2: intensIn[ii] = 4'($urandom_range(0, 15));
        default: blankIn[ii] = ~blankIn[ii];
      endcase
    end
    waitTxn(0, 8);
    waitTxn(1, 8);

    // Reset in the middle of a shift; pins must go idle at once.
    waitTxn(0, 5);
    repeat (7) @(negedge clk); #1;
    rstN = 1'b0;
    #1;
    chkIdlePins("midRst");
    repeat (3) @(negedge clk); #1;
    rstN = 1'b1;
    waitTxn(0, 8);
    waitTxn(0, 2);
    waitTxn(1, 8);
    waitTxn(1, 2);
    chk("activityA", {31'd0, txnCount[0] > 60}, 32'd1);
    chk("activityB", {31'd0, txnCount[1] > 60}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
